// File: rtl/serial_frame_rx.sv
// Serial frame receiver: deframes start/data/parity/stop bits sampled one per clock
// and hands the word to a parallel consumer through a single-entry valid/ready register.
module serial_frame_rx #(
  parameter int WIDTH      = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_perr,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             perr_q, perr_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             o_valid_q, o_valid_d;
  logic             o_perr_q, o_perr_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!i) state_d = DATA;
      DATA:    if (count_q == LAST) state_d = PARITY_EN ? PARITY : STOP;
      PARITY:  state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d     = count_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    o_d         = o_q;
    o_valid_d   = o_valid_q;
    o_perr_d    = o_perr_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (o_valid_q && o_ready) o_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        count_d = '0;
        perr_d  = 1'b0;
      end
      DATA: begin
        // Shifting in from the top leaves the first (LSB) bit at position 0 after WIDTH bits.
        shift_d = {i, shift_q[WIDTH-1:1]};
        count_d = count_q + CW'(1);
      end
      PARITY: begin
        perr_d = (^shift_q) ^ i ^ PARITY_ODD;
      end
      STOP: begin
        if (i) begin
          // A consumer taking the old word on this edge frees the slot for the new one.
          if (!o_valid_q || o_ready) begin
            o_d       = shift_q;
            o_perr_d  = PARITY_EN ? perr_q : 1'b0;
            o_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      o_q         <= '0;
      o_valid_q   <= 1'b0;
      o_perr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      shift_q     <= shift_d;
      perr_q      <= perr_d;
      o_q         <= o_d;
      o_valid_q   <= o_valid_d;
      o_perr_q    <= o_perr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o         = o_q;
  assign o_valid   = o_valid_q;
  assign o_perr    = o_perr_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: a parity-enabled instance driven from a vector
// table and hand sequences with a transfer scoreboard, plus a parity-less instance.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_a, ready_a, i_b, ready_b;
  logic [7:0] o_a, o_b;
  logic       ov_a, perr_a, ferr_a, ovr_a, busy_a;
  logic       ov_b, perr_b, ferr_b, ovr_b, busy_b;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       flip;
    logic       stop;
    logic       exp_load;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int cyc      = 0;
  int start_cyc;
  int rise_cyc = -1;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  logic prev_ov = 1'b0;

  serial_frame_rx #(.WIDTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_a (
    .clk(clk), .reset(rst_n), .i(i_a), .o(o_a), .o_valid(ov_a), .o_ready(ready_a),
    .o_perr(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a)
  );

  serial_frame_rx #(.WIDTH(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_b (
    .clk(clk), .reset(rst_n), .i(i_b), .o(o_b), .o_valid(ov_b), .o_ready(ready_b),
    .o_perr(perr_b), .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Negedge monitor: inputs are stable here, so valid&&ready means a transfer on the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov_a && ready_a) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_xfer", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("xfer_data", {24'd0, o_a}, {24'd0, e.data});
          checkOutput("xfer_perr", {31'd0, perr_a}, {31'd0, e.perr});
        end
      end
      if (ov_a && !prev_ov) rise_cyc = cyc;
      if (ferr_a) ferr_cnt++;
      if (ovr_a) ovr_cnt++;
      if (ferr_a && ovr_a) checkOutput("ferr_ovr_same_cycle", 32'd1, 32'd0);
    end
    prev_ov = ov_a;
  end

  task automatic send_bit_a(input logic b);
    i_a = b;
    @(posedge clk);
    #1;
  endtask

  // One complete frame on instance A; the parity bit is made correct, then optionally flipped.
  task automatic applyStimulus(input logic [7:0] data, input logic flip, input logic stop,
                               input logic stop_ready, input logic push, input logic exp_perr);
    exp_t e;
    send_bit_a(1'b0);
    start_cyc = cyc;
    for (int k = 0; k < 8; k++) send_bit_a(data[k]);
    send_bit_a((^data) ^ flip);
    ready_a = stop_ready;
    if (push) begin
      e.data = data;
      e.perr = exp_perr;
      sb.push_back(e);
    end
    send_bit_a(stop);
  endtask

  initial begin
    int f0, v0;
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'h6E, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; i_a = 1'b1; i_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    #1;
    checkOutput("rst_o",       {24'd0, o_a}, 32'd0);
    checkOutput("rst_valid",   {31'd0, ov_a}, 32'd0);
    checkOutput("rst_perr",    {31'd0, perr_a}, 32'd0);
    checkOutput("rst_ferr",    {31'd0, ferr_a}, 32'd0);
    checkOutput("rst_ovr",     {31'd0, ovr_a}, 32'd0);
    checkOutput("rst_busy",    {31'd0, busy_a}, 32'd0);
    checkOutput("rst_valid_b", {31'd0, ov_b}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_bit_a(1'b1);

    for (int n = 0; n < 8; n++) begin
      f0 = ferr_cnt;
      rise_cyc = -1;
      applyStimulus(vecs[n].data, vecs[n].flip, vecs[n].stop, 1'b1, vecs[n].exp_load, vecs[n].exp_perr);
      send_bit_a(1'b1);
      send_bit_a(1'b1);
      checkOutput($sformatf("v%0d_ferr_pulses", n), ferr_cnt - f0, {31'd0, vecs[n].exp_ferr});
      checkOutput($sformatf("v%0d_busy_idle", n), {31'd0, busy_a}, 32'd0);
      checkOutput($sformatf("v%0d_valid_drained", n), {31'd0, ov_a}, 32'd0);
      if (vecs[n].exp_load)
        checkOutput($sformatf("v%0d_latency", n), rise_cyc - start_cyc, 32'd10);
      else
        checkOutput($sformatf("v%0d_no_valid", n), rise_cyc, 32'hFFFF_FFFF);
    end

    // Back-to-back frames into a full holding register, then a load on the consuming edge.
    f0 = ferr_cnt; v0 = ovr_cnt;
    ready_a = 1'b0;
    applyStimulus(8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("ovr_pulse",      {31'd0, ovr_a}, 32'd1);
    checkOutput("ovr_held_valid", {31'd0, ov_a}, 32'd1);
    checkOutput("ovr_held_data",  {24'd0, o_a}, 32'h11);
    applyStimulus(8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("nobubble_valid", {31'd0, ov_a}, 32'd1);
    checkOutput("nobubble_data",  {24'd0, o_a}, 32'h33);
    send_bit_a(1'b1);
    send_bit_a(1'b1);
    checkOutput("ovr_count",  ovr_cnt - v0, 32'd1);
    checkOutput("ovr_no_ferr", ferr_cnt - f0, 32'd0);

    // Reset in the middle of a frame while a word is held.
    ready_a = 1'b0;
    applyStimulus(8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bit_a(1'b1);
    checkOutput("pre_rst_valid", {31'd0, ov_a}, 32'd1);
    send_bit_a(1'b0);
    send_bit_a(1'b1); send_bit_a(1'b0); send_bit_a(1'b1); send_bit_a(1'b1);
    checkOutput("pre_rst_busy", {31'd0, busy_a}, 32'd1);
    f0 = ferr_cnt; v0 = ovr_cnt;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy",  {31'd0, busy_a}, 32'd0);
    checkOutput("midrst_valid", {31'd0, ov_a}, 32'd0);
    checkOutput("midrst_o",     {24'd0, o_a}, 32'd0);
    checkOutput("midrst_flags", {30'd0, ferr_a, ovr_a}, 32'd0);
    i_a = 1'b1;
    ready_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_bit_a(1'b1);
    applyStimulus(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("postrst_data", {24'd0, o_a}, 32'h5A);
    send_bit_a(1'b1);
    send_bit_a(1'b1);
    checkOutput("postrst_no_flags", (ferr_cnt - f0) + (ovr_cnt - v0), 32'd0);
    checkOutput("sb_drained", sb.size(), 32'd0);

    // Parity-less instance: 0xFF then stop, valid after the ninth edge past the start edge.
    i_b = 1'b0;
    @(posedge clk); #1;
    start_cyc = cyc;
    for (int k = 0; k < 8; k++) begin
      i_b = 1'b1;
      @(posedge clk); #1;
    end
    i_b = 1'b1;
    @(posedge clk); #1;
    checkOutput("np_valid",   {31'd0, ov_b}, 32'd1);
    checkOutput("np_data",    {24'd0, o_b}, 32'hFF);
    checkOutput("np_perr",    {31'd0, perr_b}, 32'd0);
    checkOutput("np_latency", cyc - start_cyc, 32'd9);
    checkOutput("np_flags",   {29'd0, ferr_b, ovr_b, busy_b}, 32'd0);
    @(posedge clk); #1;
    checkOutput("np_drained", {31'd0, ov_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
